controller_tpu_to_bram_param: RTL and testbench
===============================================

// Module: controller_tpu_to_bram_param
// PURPOSE
//  Parametrised TPU->BRAM write controller. On a rising edge of the TPU done flag it snapshots the
//  N*N-element result matrix. It then streams the snapshot into a single-port BRAM as packed words,
//  one word per cycle, and pulses done_writing when the frame is stored.
//  Optional ping-pong banking lets the downstream stage read frame k while frame k+1 is written.
// PARAMETERS
//  DATA_W     8   bits per matrix element
//  N          4   matrix dimension; NUM_ELEMS = N*N
//  EPW        4   elements packed per BRAM word; NUM_WORDS = ceil(NUM_ELEMS/EPW)
//  ADDR_W     4   BRAM address width; must satisfy 2^ADDR_W >= NUM_WORDS*(PINGPONG+1)
//  BASE_ADDR  0   first BRAM address of bank 0
//  PINGPONG   0   1: alternate frames between bank 0 (BASE_ADDR) and bank 1 (BASE_ADDR+NUM_WORDS)
// PORTS
//  clk            in   1                  clock, all logic on rising edge
//  rst            in   1                  synchronous reset, active-high
//  data_from_TPU  in   NUM_ELEMS*DATA_W   flattened matrix; element i = [i*DATA_W +: DATA_W]
//  done           in   1                  TPU done flag (level); start = rising edge
//  ena            out  1                  BRAM enable
//  wea            out  1                  BRAM write enable
//  addra          out  ADDR_W             BRAM address
//  dina           out  EPW*DATA_W         BRAM write data
//  done_writing   out  1                  1-cycle pulse after the last word of a frame
//  busy           out  1                  high from the cycle after start until done_writing inclusive
//  bank           out  1                  bank holding the most recently completed frame (0 if PINGPONG=0)
//  overrun        out  1                  sticky: a start arrived while busy (that frame dropped)
// BEHAVIOUR
//  - All outputs are registered. On rst=1 at a clock edge, every output returns to its reset value:
//    ena=0, wea=0, addra=0, dina=0, done_writing=0, busy=0, bank=0, overrun=0.
//    Also on reset: state=IDLE, done_q=0, word counter=0, next bank=0.
//  - Edge detect: start = done & ~done_q, with done_q registering done. Because done_q resets to 0,
//    done already high at the first edge after reset counts as a start.
//  - FSM IDLE -> WRITE -> FIN -> IDLE.
//    IDLE: ena=wea=0. On start, capture data_from_TPU into the snapshot register and go to WRITE.
//          wcnt=0 and base = BASE_ADDR + (next_bank ? NUM_WORDS : 0).
//    WRITE: each cycle ena=wea=1, addra=base+wcnt (mod 2^ADDR_W), dina=word wcnt. wcnt increments.
//          After word NUM_WORDS-1, go to FIN.
//    FIN: ena=wea=0, done_writing=1 for exactly this cycle.
//          bank <= bank just written; next_bank toggles if PINGPONG=1. Return to IDLE.
//  - Latency: start sampled at edge k. Word 0 is driven in the cycle after edge k, word j in cycle
//    k+1+j. done_writing is high in cycle k+1+NUM_WORDS.
//    Minimum start-to-start spacing is NUM_WORDS+2 cycles.
//  - Packing: word w = {elem[w*EPW+EPW-1], ..., elem[w*EPW]}, so the lowest-index element is in the LSBs.
//    If NUM_ELEMS % EPW != 0, the unused high lanes of the last word are driven 0.
//  - Data is taken only from the snapshot. Changes on data_from_TPU while busy do not affect the frame.
//  - A start in WRITE or FIN is ignored: the frame in flight completes unchanged and overrun is set
//    to 1. overrun is cleared only by rst.
//  - A start in the same cycle that FIN returns to IDLE is treated as a start in FIN (dropped,
//    overrun set).
//  - done held high gives exactly one frame. A new frame needs done to go low then high again.
//  - rst mid-frame aborts the frame immediately. No further BRAM writes occur, no done_writing pulse
//    is issued, and the bank resets to 0.
//  - dina and addra hold their last values in IDLE/FIN. They are only meaningful when wea=1.
// TESTING
//  1 Defaults, elements 0..15 = 0x00..0x0F, done 0->1 at edge k.
//    -> writes addr 0..3, dina 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in cycles k+1..k+4;
//       done_writing=1 only in cycle k+5.
//  2 Change data_from_TPU every cycle during WRITE.
//    -> written words equal the values captured at the start edge.
//  3 PINGPONG=1, three frames.
//    -> base addresses 0, 4, 0; bank after each done_writing = 0, 1, 0.
//  4 Second done edge arrives in word 2 of a frame.
//    -> frame completes with 4 writes, overrun=1 and stays 1, no second frame.
//       overrun clears after rst.
//  5 N=3, EPW=4 (NUM_ELEMS=9, NUM_WORDS=3).
//    -> last word = {24'h0, elem8}; done_writing in cycle k+4.
//  6 rst asserted in word 1; done held high through and after reset.
//    -> wea=0 from the next cycle, no done_writing for the aborted frame.
//       A new frame starts at the first edge after rst drops.

Source files
------------

// File: rtl/controller_tpu_to_bram_param.sv
// TPU->BRAM write controller: snapshots the N*N result matrix on a rising done edge and
// streams it into a single-port BRAM as packed words, optionally alternating between two banks.
module controller_tpu_to_bram_param #(
  parameter int DATA_W    = 8,
  parameter int N         = 4,
  parameter int EPW       = 4,
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0,
  parameter int PINGPONG  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N*N*DATA_W-1:0]      data_from_TPU,
  input  logic                       done,
  output logic                       ena,
  output logic                       wea,
  output logic [ADDR_W-1:0]          addra,
  output logic [EPW*DATA_W-1:0]      dina,
  output logic                       done_writing,
  output logic                       busy,
  output logic                       bank,
  output logic                       overrun
);

  localparam int NUM_ELEMS = N * N;
  localparam int NUM_WORDS = (NUM_ELEMS + EPW - 1) / EPW;
  localparam int WORD_W    = EPW * DATA_W;
  localparam int MAT_W     = NUM_ELEMS * DATA_W;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  localparam logic [ADDR_W-1:0] BANK0_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BASE_ADDR + NUM_WORDS);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

  state_t             state;
  logic               done_q;
  logic               start;
  logic [MAT_W-1:0]   snap;
  logic [CNT_W-1:0]   wcnt;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  base_sel;
  logic               next_bank;
  logic               cur_bank;

  // Lowest-index element lands in the LSBs; lanes past the last element stay zero.
  function automatic logic [WORD_W-1:0] pack_word(input logic [MAT_W-1:0] m,
                                                  input logic [CNT_W-1:0] w);
    logic [WORD_W-1:0] r;
    int idx;
    r = '0;
    for (int l = 0; l < EPW; l++) begin
      idx = int'(w) * EPW + l;
      if (idx < NUM_ELEMS)
        r[l*DATA_W +: DATA_W] = m[idx*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  assign start    = done & ~done_q;
  assign base_sel = next_bank ? BANK1_BASE : BANK0_BASE;

  // Word 0 is issued on the start edge straight from the live input (identical to the
  // snapshot being captured), so the remaining words follow from the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      done_q       <= 1'b0;
      snap         <= '0;
      wcnt         <= '0;
      base         <= '0;
      next_bank    <= 1'b0;
      cur_bank     <= 1'b0;
      ena          <= 1'b0;
      wea          <= 1'b0;
      addra        <= '0;
      dina         <= '0;
      done_writing <= 1'b0;
      busy         <= 1'b0;
      bank         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done_q <= done;
      case (state)
        IDLE: begin
          ena          <= 1'b0;
          wea          <= 1'b0;
          done_writing <= 1'b0;
          if (start) begin
            snap     <= data_from_TPU;
            base     <= base_sel;
            cur_bank <= next_bank;
            ena      <= 1'b1;
            wea      <= 1'b1;
            addra    <= base_sel;
            dina     <= pack_word(data_from_TPU, '0);
            wcnt     <= CNT_W'(1);
            busy     <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (start)
            overrun <= 1'b1;
          if (wcnt == LAST_CNT) begin
            ena          <= 1'b0;
            wea          <= 1'b0;
            done_writing <= 1'b1;
            bank         <= cur_bank;
            if (PINGPONG != 0)
              next_bank <= ~next_bank;
            state        <= FIN;
          end else begin
            addra <= base + ADDR_W'(wcnt);
            dina  <= pack_word(snap, wcnt);
            wcnt  <= wcnt + CNT_W'(1);
          end
        end
        FIN: begin
          // A start landing on the FIN->IDLE edge still counts as arriving while busy.
          if (start)
            overrun <= 1'b1;
          done_writing <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_tpu_to_bram_param.sv
// Scoreboard bench for controller_tpu_to_bram_param: three instances (default, ping-pong, N=3)
// driven by shared random stimulus and checked against a frame-level timing model.
module tb_controller_tpu_to_bram_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] elem [16];
  logic [127:0] data16;
  logic [71:0]  data9;

  logic        ena_o  [3];
  logic        wea_o  [3];
  logic [3:0]  addra_o[3];
  logic [31:0] dina_o [3];
  logic        dw_o   [3];
  logic        busy_o [3];
  logic        bank_o [3];
  logic        ovr_o  [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    data16 = '0;
    data9  = '0;
    for (int i = 0; i < 16; i++) data16[i*8 +: 8] = elem[i];
    for (int i = 0; i < 9; i++)  data9[i*8 +: 8]  = elem[i];
  end

  controller_tpu_to_bram_param u_def (
    .clk(clk), .rst(rst), .data_from_TPU(data16), .done(done),
    .ena(ena_o[0]), .wea(wea_o[0]), .addra(addra_o[0]), .dina(dina_o[0]),
    .done_writing(dw_o[0]), .busy(busy_o[0]), .bank(bank_o[0]), .overrun(ovr_o[0]));

  controller_tpu_to_bram_param #(.PINGPONG(1)) u_pp (
    .clk(clk), .rst(rst), .data_from_TPU(data16), .done(done),
    .ena(ena_o[1]), .wea(wea_o[1]), .addra(addra_o[1]), .dina(dina_o[1]),
    .done_writing(dw_o[1]), .busy(busy_o[1]), .bank(bank_o[1]), .overrun(ovr_o[1]));

  controller_tpu_to_bram_param #(.N(3)) u_n3 (
    .clk(clk), .rst(rst), .data_from_TPU(data9), .done(done),
    .ena(ena_o[2]), .wea(wea_o[2]), .addra(addra_o[2]), .dina(dina_o[2]),
    .done_writing(dw_o[2]), .busy(busy_o[2]), .bank(bank_o[2]), .overrun(ovr_o[2]));

  function automatic int nw_of(int id); return (id == 2) ? 3 : 4; endfunction
  function automatic int ne_of(int id); return (id == 2) ? 9 : 16; endfunction
  function automatic bit pp_of(int id); return (id == 1); endfunction

  function automatic logic [31:0] exp_word(int ne, int w);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 4; l++)
      if (w * 4 + l < ne) r[l*8 +: 8] = elem[w*4 + l];
    return r;
  endfunction

  task automatic cmp(string name, int id, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, id, act, exp, $time);
    end
  endtask

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t wq [3][$];
  bit  bq [3][$];
  int  acc [3];
  bit  acc_v [3];
  bit  ovr_m [3];
  bit  nb [3];
  bit  chk_bank [3];
  bit  pend_bank [3];
  bit  prev_done = 1'b0;
  int  e = 0;
  wr_t mt;
  int  mbase;

  // Frame-level reference: a start is accepted only if NUM_WORDS+2 edges have passed since
  // the last accepted one; each accepted frame queues its expected writes and bank.
  always @(posedge clk) begin
    e = e + 1;
    for (int id = 0; id < 3; id++) begin
      if (rst) begin
        wq[id].delete();
        bq[id].delete();
        acc_v[id]    = 1'b0;
        ovr_m[id]    = 1'b0;
        nb[id]       = 1'b0;
        chk_bank[id] = 1'b0;
      end else if (done && !prev_done) begin
        if (acc_v[id] && e < acc[id] + nw_of(id) + 2) begin
          ovr_m[id] = 1'b1;
        end else begin
          acc_v[id] = 1'b1;
          acc[id]   = e;
          mbase     = (pp_of(id) && nb[id]) ? nw_of(id) : 0;
          for (int w = 0; w < nw_of(id); w++) begin
            mt.addr = (mbase + w) % 16;
            mt.data = exp_word(ne_of(id), w);
            wq[id].push_back(mt);
          end
          bq[id].push_back(nb[id]);
          if (pp_of(id)) nb[id] = !nb[id];
        end
      end
    end
    prev_done = rst ? 1'b0 : done;
  end

  // Monitor: pops the scoreboard whenever a DUT writes or signals frame completion.
  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      bit in_frame;
      wr_t t;
      in_frame = acc_v[id] && (e >= acc[id]);
      cmp("wea", id, 64'(wea_o[id]), 64'(in_frame && (e < acc[id] + nw_of(id))));
      cmp("ena", id, 64'(ena_o[id]), 64'(in_frame && (e < acc[id] + nw_of(id))));
      cmp("busy", id, 64'(busy_o[id]), 64'(in_frame && (e <= acc[id] + nw_of(id))));
      cmp("done_writing", id, 64'(dw_o[id]), 64'(in_frame && (e == acc[id] + nw_of(id))));
      cmp("overrun", id, 64'(ovr_o[id]), 64'(ovr_m[id]));
      if (chk_bank[id]) begin
        cmp("bank", id, 64'(bank_o[id]), 64'(pend_bank[id]));
        chk_bank[id] = 1'b0;
      end
      if (wea_o[id]) begin
        if (wq[id].size() == 0) begin
          cmp("unexpected_write", id, 64'(1), 64'(0));
        end else begin
          t = wq[id].pop_front();
          cmp("addra", id, 64'(addra_o[id]), 64'(t.addr));
          cmp("dina", id, 64'(dina_o[id]), 64'(t.data));
        end
      end
      if (dw_o[id]) begin
        cmp("words_left_at_done", id, 64'(wq[id].size()), 64'(0));
        if (bq[id].size() != 0) begin
          pend_bank[id] = bq[id].pop_front();
          chk_bank[id]  = 1'b1;
        end
      end
    end
  end

  task automatic tick(int n, bit rnd);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd)
        for (int i = 0; i < 16; i++) elem[i] = 8'($urandom);
    end
  endtask

  task automatic applyStimulus(bit d, int n);
    done = d;
    tick(n, 1'b1);
  endtask

  task automatic checkOutput();
    for (int id = 0; id < 3; id++) begin
      cmp("rst_ena", id, 64'(ena_o[id]), 64'(0));
      cmp("rst_wea", id, 64'(wea_o[id]), 64'(0));
      cmp("rst_addra", id, 64'(addra_o[id]), 64'(0));
      cmp("rst_dina", id, 64'(dina_o[id]), 64'(0));
      cmp("rst_done_writing", id, 64'(dw_o[id]), 64'(0));
      cmp("rst_busy", id, 64'(busy_o[id]), 64'(0));
      cmp("rst_bank", id, 64'(bank_o[id]), 64'(0));
      cmp("rst_overrun", id, 64'(ovr_o[id]), 64'(0));
    end
  endtask

  initial begin
    rst  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 16; i++) elem[i] = 8'(i);
    tick(3, 1'b0);
    checkOutput();
    rst = 1'b0;
    tick(1, 1'b0);

    $display("[TB] ramp frame, input scrambled while writing");
    done = 1'b1;
    tick(1, 1'b0);
    applyStimulus(1'b1, 7);
    applyStimulus(1'b0, 3);

    $display("[TB] random frames");
    repeat (25) begin
      applyStimulus(1'b1, $urandom_range(1, 3));
      applyStimulus(1'b0, $urandom_range(1, 8));
    end

    $display("[TB] overrun during word 2");
    rst = 1'b1;
    tick(2, 1'b1);
    checkOutput();
    rst = 1'b0;
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 8);
    rst = 1'b1;
    tick(1, 1'b1);
    checkOutput();
    rst = 1'b0;
    applyStimulus(1'b0, 2);

    $display("[TB] reset during word 1 with done held");
    applyStimulus(1'b1, 2);
    rst = 1'b1;
    tick(2, 1'b1);
    checkOutput();
    rst = 1'b0;
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 2);

    $display("[TB] spaced random frames");
    repeat (10) begin
      applyStimulus(1'b1, $urandom_range(1, 2));
      applyStimulus(1'b0, $urandom_range(6, 10));
    end
    tick(10, 1'b0);

    for (int id = 0; id < 3; id++) begin
      cmp("drain_writes", id, 64'(wq[id].size()), 64'(0));
      cmp("drain_frames", id, 64'(bq[id].size()), 64'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
